// File: rtl/mem_pkg.sv
// Shared widths and the load-stage slot type for the memory access front-end.
package mem_pkg;

  localparam int unsigned MEM_DATA_W = 16;
  localparam int unsigned MEM_ADDR_W = 9;

  typedef struct packed {
    logic                  valid;
    logic                  fwd;
    logic [MEM_DATA_W-1:0] fwd_data;
  } ld_slot_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous FIFO with registered storage; head is the oldest entry.
module rsp_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 3,
  localparam int unsigned cnt_w = $clog2(depth + 1),
  localparam int unsigned ptr_w = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [cnt_w-1:0] count,
  output logic [width-1:0] head
);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] rd_ptr;
  logic [ptr_w-1:0] wr_ptr;
  logic             do_pop;

  // Pointers wrap at depth explicitly since depth need not be a power of two.
  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end owning both ports of the data RAM, with write-first
// forwarding for same-cycle collisions and a credit-limited response FIFO.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned data_width = MEM_DATA_W,
  parameter int unsigned addr_width = MEM_ADDR_W,
  parameter int unsigned rsp_depth  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [addr_width-1:0] ld_addr,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [addr_width-1:0] st_addr,
  input  logic [data_width-1:0] st_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_data,
  output logic [addr_width-1:0] ram_read_address,
  output logic [addr_width-1:0] ram_write_address,
  output logic                  ram_write,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  localparam int unsigned cnt_w = $clog2(rsp_depth + 1);

  ld_slot_t              s1;
  logic [cnt_w-1:0]      count;
  logic [cnt_w:0]        outstanding;
  logic                  ld_fire;
  logic                  st_fire;
  logic [data_width-1:0] push_data;

  assign st_ready          = !reset;
  assign st_fire           = st_valid && st_ready;
  assign ram_write         = st_fire;
  assign ram_write_address = st_addr;
  assign ram_din           = st_data;

  // Credits count both buffered results and the one still in the RAM pipe,
  // so the FIFO can never overflow and rsp_ready never reaches ld_ready.
  assign outstanding      = {1'b0, count} + (cnt_w + 1)'(s1.valid);
  assign ld_ready         = !reset && (outstanding < (cnt_w + 1)'(rsp_depth));
  assign ld_fire          = ld_valid && ld_ready;
  assign ram_read_address = ld_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1.valid    <= ld_fire;
      s1.fwd      <= ld_fire && st_fire && (ld_addr == st_addr);
      s1.fwd_data <= st_data;
    end
  end

  // RAM returns old data on a same-address collision; substitute the store.
  assign push_data = s1.fwd ? s1.fwd_data : ram_dout;
  assign rsp_valid = (count != '0);

  rsp_fifo #(
    .width(data_width),
    .depth(rsp_depth)
  ) u_rsp_fifo (
    .clk  (clk),
    .reset(reset),
    .push (s1.valid),
    .din  (push_data),
    .pop  (rsp_ready),
    .count(count),
    .head (rsp_data)
  );

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end for the dual-port data RAM (simple dual-port, 1-cycle synchronous read, old-data read-during-write).
- Sits directly upstream of the RAM in the memory stage and owns both RAM ports.
- Accepts independent load and store channels with valid/ready handshakes and converts RAM old-data collisions into write-first semantics.
- Buffers load results in a response FIFO so back-pressure never loses RAM output.

Parameters:
- data_width, 16, word width; equals the RAM's data width.
- addr_width, 9, word address width; equals the RAM's address width.
- rsp_depth, 3, response FIFO entries; must be >= 2; 3 gives one load per cycle with rsp_ready held high.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- ld_valid  in  1  load request valid.
- ld_ready  out  1  load request accepted when ld_valid && ld_ready.
- ld_addr  in  addr_width  load word address.
- st_valid  in  1  store request valid.
- st_ready  out  1  store request accepted when st_valid && st_ready.
- st_addr  in  addr_width  store word address.
- st_data  in  data_width  store data.
- rsp_valid  out  1  load result valid.
- rsp_ready  in  1  consumer takes result when rsp_valid && rsp_ready.
- rsp_data  out  data_width  load result, FIFO head.
- ram_read_address  out  addr_width  to RAM read_address.
- ram_write_address  out  addr_width  to RAM write_address.
- ram_write  out  1  to RAM write.
- ram_din  out  data_width  to RAM din.
- ram_dout  in  data_width  from RAM dout, valid the cycle after the read address is presented.

Behaviour:
- Reset (sync): s1_valid=0, FIFO count=0, pointers=0, rsp_valid=0, rsp_data=0. While reset=1: ld_ready=0, st_ready=0, ram_write=0. Reset mid-operation discards in-flight and buffered loads; no response is ever produced for them.
- Stores:
  - st_ready = !reset; stores never stall.
  - ram_write = st_valid && st_ready, combinational.
  - ram_write_address = st_addr; ram_din = st_data.
  - RAM is updated at the same edge the store fires. Stores produce no response.
- Loads:
  - ld_ready = !reset && (count + s1_valid) < rsp_depth, computed from registers only; no combinational path from rsp_ready.
  - ram_read_address = ld_addr whenever a load fires.
  - On ld_fire: s1_valid <= 1, otherwise 0.
- Collision forwarding:
  - Condition: ld_fire && st_fire && ld_addr == st_addr in the same cycle.
  - Action: s1_fwd <= 1, s1_fwd_data <= st_data.
  - Rule: a same-cycle store is ordered older than the load (write-first).
  - A store in a later cycle does not affect an earlier load.
- Capture: when s1_valid=1, push (s1_fwd ? s1_fwd_data : ram_dout) into the FIFO in that cycle. ram_dout is never sampled later than one cycle after issue.
- Latency: load fire at cycle N produces the FIFO push at N+1, with rsp_valid=1 from N+2 at the earliest.
- FIFO:
  - rsp_valid = count != 0; rsp_data = head entry, registered.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap explicitly at rsp_depth, which need not be a power of 2.
  - Overflow is impossible by the ld_ready credit rule. A pop when empty is ignored.
- Ordering: responses are returned strictly in load-acceptance order.
- Throughput (rsp_depth=3, rsp_ready=1): one load per cycle sustained.
- Throughput (rsp_ready=0): accepts exactly rsp_depth loads, then ld_ready=0 until a pop occurs.

Decomposition:
- Shared package mem_pkg holds:
  - the default widths MEM_DATA_W=16 and MEM_ADDR_W=9;
  - typedef ld_slot_t, a struct with fields valid, fwd and fwd_data.
- Sub-module: rsp_fifo, a synchronous FIFO with parameters width and depth, ports push/pop/count/head, and synchronous reset.
- Collision detect, credit logic and the s1 register stay in mem_access_unit.

Test Plan:
- Preload mem[5]=0x1234; load addr 5 with rsp_ready=1 -> rsp_valid at N+2, rsp_data=0x1234, one cycle.
- Same cycle: store addr 7 data 0xBEEF and load addr 7 -> response 0xBEEF, not old data; next load of 7 also returns 0xBEEF.
- Store addr 9=0x00AA at N, load addr 9 at N+1 -> 0x00AA; load addr 9 at N with store to addr 10 -> returns the old mem[9].
- Hold rsp_ready=0 and stream loads to addrs 1,2,3,4 -> exactly 3 accepted and ld_ready=0. Release rsp_ready -> responses in order 1,2,3, then addr 4 is accepted.
- Stream 8 back-to-back loads with rsp_ready=1 -> 8 responses on 8 consecutive cycles with no ld_ready drop, and pointers wrap correctly.
- Assert reset with 2 responses buffered and 1 load in flight -> next cycle rsp_valid=0, ld_ready=0, ram_write=0. After release, no stale responses appear.
